cordic_rotate: RTL and testbench
================================

Name: cordic_rotate

Overview:
Fully pipelined fixed-point CORDIC vector rotator. Rotates the input vector (x, y) by angle a and outputs xo = x·cos(a) − y·sin(a) and yo = x·sin(a) + y·cos(a), with CORDIC gain compensated. It sits between the sprite/geometry logic (e.g. rotating ant-sprite pixel offsets about the sprite centre) and the display path. It accepts one sample per clock.

Parameters:
ITER, 14, number of CORDIC micro-rotation stages.
LATENCY, 19, input-to-output latency in clk cycles; fixed as 5 + ITER.

Ports:
clk  input  1  system clock; all registers rise-edge triggered.
areset  input  1  asynchronous, active-low reset (asserted at 0).
a  input  13  rotation angle, signed two's complement Q2.10 radians (LSB = 2^-10).
x  input  12  input x, signed Q1.10 (LSB = 2^-10, range [-2, 2)).
y  input  12  input y, signed Q1.10.
xo  output  10  rotated x, signed Q1.8 (LSB = 2^-8, range [-2, 2)).
yo  output  10  rotated y, signed Q1.8.

Behaviour:
- Reset: while areset=0, all pipeline registers clear asynchronously; xo=yo=0 immediately.
- After reset release, xo and yo stay 0 until the first post-reset sample has traversed the pipe, i.e. for LATENCY cycles.
- No handshake. A new (a, x, y) is sampled every rising clk edge. Its result appears on xo/yo exactly LATENCY (19) edges later. Order is preserved and throughput is 1 sample per cycle.
- A reset asserted mid-stream flushes all in-flight samples. None of them emerge afterwards.
- Pipeline stages:
  - 1 input register.
  - 1 angle clamp plus quadrant pre-rotation: if a > π/2, rotate by +π/2 (x' = −y, y' = x, a' = a − π/2); if a < −π/2, the mirror case.
  - ITER micro-rotation stages. Stage i uses shift i and constant atan(2^-i). Direction is set by the sign of the residual angle.
  - 1 gain-compensation multiply by 1/K ≈ 0.607253.
  - 1 round/saturate.
  - 1 output register.
- Angle range: a is clamped to [−3217, +3217] codes (±π) before pre-rotation.
- Internal datapath: x/y at least 16 bits signed (2 guard integer bits, 12 fraction bits). Residual angle at least 16 bits with 13 fraction bits. atan constants are rounded to nearest.
- Output conversion: round to nearest (ties away from zero) to 8 fraction bits. Saturate to [−512, +511] codes; there is no wrap-around. Magnitudes up to 2√2 are possible, so saturation is reachable.
- Accuracy: |error| ≤ 2 output LSB for every in-range input that does not saturate.

Decomposition:
- Shared package cordic_pkg holds:
  - width constants (13/12/10 bits, fraction counts 10 and 8);
  - PI and PI_2 codes in Q2.10 (3217, 1608);
  - the atan(2^-i) table as a constant function or array;
  - the 1/K constant.
- One sub-module is natural: cordic_stage (a single micro-rotation register stage, parameterised by shift index), instantiated ITER times via generate.
- bin7seghex (4-bit to 7-segment hex decoder) is a separate existing combinational module used by the display path. It is not part of this block.

Test Plan:
- Reset: hold areset=0 with nonzero inputs → xo=yo=0. Release and drive a=0, x=12'h200 (0.5), y=0 → outputs stay 0 for 18 edges. On the 19th edge xo=10'h080, yo=10'h000 (±1 LSB).
- a=13'h0648 (π/2), x=12'h200, y=0 → after 19 cycles xo=0 ±2 LSB, yo=10'h080 ±2 LSB.
- a=13'h0324 (π/4), x=12'h200, y=0 → xo=yo≈0.3536 → 10'h05A ±2 LSB each.
- a=13'h0C91 (π), x=12'h200, y=0 → xo=10'h380 (−0.5) ±2 LSB, yo≈0.
- Throughput: stream 27 consecutive x values 1..27 (x=n·2^-6), with a=π/4 and y=0 → 27 consecutive outputs, in order, starting exactly 19 cycles after the first input. Each output matches n·2^-6·cos(π/4) within 2 LSB. Then assert areset mid-stream → outputs drop to 0 immediately and no stale samples emerge.
- Saturation: x=y=12'h7FF (≈2), a=π/4 → yo=10'h1FF, xo≈0. With a=−3π/4, both outputs are clamped where they exceed the range (xo=10'h200 in the negative direction where applicable). Also drive a=13'h0FFF (beyond π) → result equals that for a=3217.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared widths, angle constants and arithmetic helpers for the pipelined CORDIC rotator.
package cordic_pkg;
  localparam int A_W         = 13;
  localparam int XY_W        = 12;
  localparam int O_W         = 10;
  localparam int IN_FRAC     = 10;
  localparam int OUT_FRAC    = 8;
  localparam int D_W         = 16;
  localparam int D_FRAC      = 12;
  localparam int Z_W         = 16;
  localparam int Z_FRAC      = 13;
  localparam int CORDIC_ITER = 14;
  localparam int LATENCY     = 5 + CORDIC_ITER;

  localparam logic signed [A_W-1:0] PI_CODE   = 13'sd3217;
  localparam logic signed [A_W-1:0] PI_2_CODE = 13'sd1608;
  // pi/2 at the residual-angle resolution, so pre-rotation adds no angle bias
  localparam logic signed [Z_W-1:0] PI_2_Z    = 16'sd12868;

  localparam int K_W    = 17;
  localparam int K_FRAC = 15;
  localparam logic signed [K_W-1:0] INV_K = 17'sd19899;

  localparam int P_W    = D_W + K_W;
  localparam int RND_SH = D_FRAC + K_FRAC - OUT_FRAC;
  localparam int Q_W    = P_W + 1 - RND_SH;

  localparam logic signed [O_W-1:0] O_MAX = 10'sh1FF;
  localparam logic signed [O_W-1:0] O_MIN = 10'sh200;

  function automatic logic signed [Z_W-1:0] atan_q13(input logic [4:0] i);
    case (i)
      5'd0:    atan_q13 = 16'sd6434;
      5'd1:    atan_q13 = 16'sd3798;
      5'd2:    atan_q13 = 16'sd2007;
      5'd3:    atan_q13 = 16'sd1019;
      5'd4:    atan_q13 = 16'sd511;
      5'd5:    atan_q13 = 16'sd256;
      5'd6:    atan_q13 = 16'sd128;
      5'd7:    atan_q13 = 16'sd64;
      5'd8:    atan_q13 = 16'sd32;
      5'd9:    atan_q13 = 16'sd16;
      5'd10:   atan_q13 = 16'sd8;
      5'd11:   atan_q13 = 16'sd4;
      5'd12:   atan_q13 = 16'sd2;
      5'd13:   atan_q13 = 16'sd1;
      default: atan_q13 = 16'sd0;
    endcase
  endfunction

  // Round half away from zero down to the output grid, then clamp instead of wrapping.
  function automatic logic signed [O_W-1:0] round_sat(input logic signed [P_W-1:0] p);
    logic signed [P_W:0] half;
    logic signed [P_W:0] sum;
    logic signed [Q_W-1:0] q;
    half = {{Q_W{1'b0}}, 1'b1, {(RND_SH-1){1'b0}}};
    if (p[P_W-1]) begin
      sum = {p[P_W-1], p} + half - {{P_W{1'b0}}, 1'b1};
    end else begin
      sum = {p[P_W-1], p} + half;
    end
    q = sum[P_W:RND_SH];
    if (q > O_MAX) begin
      round_sat = O_MAX;
    end else if (q < O_MIN) begin
      round_sat = O_MIN;
    end else begin
      round_sat = q[O_W-1:0];
    end
  endfunction
endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; direction follows the sign of the residual angle.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic signed [D_W-1:0] x,
  input  logic signed [D_W-1:0] y,
  input  logic signed [Z_W-1:0] z,
  output logic signed [D_W-1:0] x_r,
  output logic signed [D_W-1:0] y_r,
  output logic signed [Z_W-1:0] z_r
);
  localparam logic signed [Z_W-1:0] ATAN_STEP = atan_q13(5'(SHIFT));

  logic signed [D_W-1:0] x_sh_s;
  logic signed [D_W-1:0] y_sh_s;

  assign x_sh_s = x >>> SHIFT;
  assign y_sh_s = y >>> SHIFT;

  // Micro-rotation register: rotate toward a zero residual angle.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      x_r <= {D_W{1'b0}};
      y_r <= {D_W{1'b0}};
      z_r <= {Z_W{1'b0}};
    end else if (z[Z_W-1]) begin
      x_r <= x + y_sh_s;
      y_r <= y - x_sh_s;
      z_r <= z + ATAN_STEP;
    end else begin
      x_r <= x - y_sh_s;
      y_r <= y + x_sh_s;
      z_r <= z - ATAN_STEP;
    end
  end
endmodule

// File: rtl/cordic_rotate.sv
// Fully pipelined gain-compensated CORDIC vector rotator, one sample per clock.
module cordic_rotate
  import cordic_pkg::*;
#(
  parameter int ITER = CORDIC_ITER
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic signed [A_W-1:0]  a,
  input  logic signed [XY_W-1:0] x,
  input  logic signed [XY_W-1:0] y,
  output logic signed [O_W-1:0]  xo,
  output logic signed [O_W-1:0]  yo
);
  logic signed [A_W-1:0]  a_r;
  logic signed [XY_W-1:0] x_r;
  logic signed [XY_W-1:0] y_r;
  logic signed [A_W-1:0]  a_clamp_s;
  logic signed [D_W-1:0]  x_ext_s, y_ext_s, rot_x_s, rot_y_s;
  logic signed [Z_W-1:0]  z_ext_s, rot_z_s;
  logic signed [D_W-1:0]  pre_x_r, pre_y_r;
  logic signed [Z_W-1:0]  pre_z_r;
  logic signed [D_W-1:0]  sx_s [ITER+1];
  logic signed [D_W-1:0]  sy_s [ITER+1];
  logic signed [Z_W-1:0]  sz_s [ITER+1];
  logic signed [P_W-1:0]  prod_x_r, prod_y_r;
  logic signed [O_W-1:0]  rnd_x_r, rnd_y_r, out_x_r, out_y_r;

  // Input capture register.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      a_r <= {A_W{1'b0}};
      x_r <= {XY_W{1'b0}};
      y_r <= {XY_W{1'b0}};
    end else begin
      a_r <= a;
      x_r <= x;
      y_r <= y;
    end
  end

  // Clamp to +/-pi, widen to the internal grid and fold outer quadrants by +/-pi/2.
  always_comb begin
    a_clamp_s = a_r;
    if (a_r > PI_CODE) begin
      a_clamp_s = PI_CODE;
    end else if (a_r < -PI_CODE) begin
      a_clamp_s = -PI_CODE;
    end else begin
      a_clamp_s = a_r;
    end
    x_ext_s = {{(D_W-XY_W-(D_FRAC-IN_FRAC)){x_r[XY_W-1]}}, x_r, {(D_FRAC-IN_FRAC){1'b0}}};
    y_ext_s = {{(D_W-XY_W-(D_FRAC-IN_FRAC)){y_r[XY_W-1]}}, y_r, {(D_FRAC-IN_FRAC){1'b0}}};
    z_ext_s = {a_clamp_s, {(Z_FRAC-IN_FRAC){1'b0}}};
    if (a_clamp_s > PI_2_CODE) begin
      rot_x_s = -y_ext_s;
      rot_y_s = x_ext_s;
      rot_z_s = z_ext_s - PI_2_Z;
    end else if (a_clamp_s < -PI_2_CODE) begin
      rot_x_s = y_ext_s;
      rot_y_s = -x_ext_s;
      rot_z_s = z_ext_s + PI_2_Z;
    end else begin
      rot_x_s = x_ext_s;
      rot_y_s = y_ext_s;
      rot_z_s = z_ext_s;
    end
  end

  // Pre-rotation register.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      pre_x_r <= {D_W{1'b0}};
      pre_y_r <= {D_W{1'b0}};
      pre_z_r <= {Z_W{1'b0}};
    end else begin
      pre_x_r <= rot_x_s;
      pre_y_r <= rot_y_s;
      pre_z_r <= rot_z_s;
    end
  end

  assign sx_s[0] = pre_x_r;
  assign sy_s[0] = pre_y_r;
  assign sz_s[0] = pre_z_r;

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    cordic_stage #(.SHIFT(i)) u_stage (
      .clk    (clk),
      .areset (areset),
      .x      (sx_s[i]),
      .y      (sy_s[i]),
      .z      (sz_s[i]),
      .x_r    (sx_s[i+1]),
      .y_r    (sy_s[i+1]),
      .z_r    (sz_s[i+1])
    );
  end

  // Gain compensation, then round/saturate, then the output register.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      prod_x_r <= {P_W{1'b0}};
      prod_y_r <= {P_W{1'b0}};
      rnd_x_r  <= {O_W{1'b0}};
      rnd_y_r  <= {O_W{1'b0}};
      out_x_r  <= {O_W{1'b0}};
      out_y_r  <= {O_W{1'b0}};
    end else begin
      prod_x_r <= P_W'(sx_s[ITER]) * P_W'(INV_K);
      prod_y_r <= P_W'(sy_s[ITER]) * P_W'(INV_K);
      rnd_x_r  <= round_sat(prod_x_r);
      rnd_y_r  <= round_sat(prod_y_r);
      out_x_r  <= rnd_x_r;
      out_y_r  <= rnd_y_r;
    end
  end

  assign xo = out_x_r;
  assign yo = out_y_r;
endmodule

// File: tb/tb_cordic_rotate.sv
// Directed bench for cordic_rotate: reset, latency, angles, streaming, mid-stream flush, saturation.
module tb_cordic_rotate;
  logic clk = 1'b0;
  logic areset;
  logic signed [12:0] a;
  logic signed [11:0] x;
  logic signed [11:0] y;
  logic signed [9:0]  xo;
  logic signed [9:0]  yo;
  int tests = 0;
  int fails = 0;

  cordic_rotate dut (
    .clk    (clk),
    .areset (areset),
    .a      (a),
    .x      (x),
    .y      (y),
    .xo     (xo),
    .yo     (yo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [9:0] obs, input int expv, input int tol);
    int d;
    d = int'(obs) - expv;
    if (d < 0) d = -d;
    tests++;
    assert ((d <= tol) === 1'b1)
      else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, expv, tol);
      end
  endtask

  task automatic settle(input string tag, input logic signed [12:0] av, input logic signed [11:0] xv,
                        input logic signed [11:0] yv, input int exo, input int tolx, input int eyo,
                        input int toly);
    a = av;
    x = xv;
    y = yv;
    repeat (19) tick();
    check({tag, "_xo"}, xo, exo, tolx);
    check({tag, "_yo"}, yo, eyo, toly);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e;
    areset = 1'b0;
    a = 13'sd804;
    x = 12'sd1023;
    y = 12'sd500;
    repeat (3) tick();
    check("rst_xo", xo, 0, 0);
    check("rst_yo", yo, 0, 0);

    // First sample needs 19 edges; the 18 before it show the cleared pipe.
    areset = 1'b1;
    a = 13'sd0;
    x = 12'sh200;
    y = 12'sd0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      check("fill_xo", xo, 0, 0);
      check("fill_yo", yo, 0, 0);
    end
    tick();
    check("first_xo", xo, 128, 1);
    check("first_yo", yo, 0, 1);

    settle("pi2", 13'sd1608, 12'sh200, 12'sd0, 0, 2, 128, 2);
    settle("pi4", 13'sd804, 12'sh200, 12'sd0, 90, 2, 90, 2);
    settle("pi", 13'sd3217, 12'sh200, 12'sd0, -128, 2, 0, 2);
    settle("sat_p4", 13'sd804, 12'sd2047, 12'sd2047, 0, 2, 511, 0);
    settle("sat_m3p4", -13'sd2413, 12'sd2047, 12'sd2047, 0, 2, -512, 0);
    settle("clamp_pi", 13'sd3217, 12'sh200, 12'sh100, -128, 2, -64, 2);
    settle("beyond_pi", 13'sh0FFF, 12'sh200, 12'sh100, -128, 2, -64, 2);

    // Stream x = n*2^-6 at pi/4 behind a pipe full of zeros.
    a = 13'sd804;
    x = 12'sd0;
    y = 12'sd0;
    repeat (19) tick();
    for (int c = 0; c < 45; c++) begin
      x = (c < 27) ? 12'((c + 1) * 16) : 12'sd0;
      tick();
      n = c - 17;
      e = (n >= 1 && n <= 27) ? (n * 2828 + 500) / 1000 : 0;
      check("stream_xo", xo, e, 2);
      check("stream_yo", yo, e, 2);
    end

    // Reset while samples are in flight: outputs clear at once, nothing stale follows.
    for (int c = 0; c < 25; c++) begin
      x = 12'((c + 1) * 40);
      tick();
    end
    check("pre_flush_xo", xo, 50, 2);
    areset = 1'b0;
    x = 12'sd0;
    #1;
    check("flush_xo", xo, 0, 0);
    check("flush_yo", yo, 0, 0);
    #2;
    areset = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      check("stale_xo", xo, 0, 0);
      check("stale_yo", yo, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
